// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences fetch/decode/exec/mem/wb, memory handshakes, timeouts and traps.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] opcode_i,
    input  logic       branch_taken_i,
    output logic       imem_req_o,
    input  logic       imem_rvalid_i,
    output logic       dmem_req_o,
    output logic       dmem_we_o,
    input  logic       dmem_rvalid_i,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_sel_o,
    output logic       rf_we_o,
    output logic [1:0] wb_sel_o,
    output logic [1:0] alu_a_sel_o,
    output logic       alu_b_imm_o,
    output logic       instr_retired_o,
    output logic [2:0] state_o,
    output logic       illegal_o,
    output logic       bus_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic             berr_q, berr_d;

    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c;
    logic       pc_we_c, rf_we_c, retired_c, alu_b_imm_c;
    logic [1:0] pc_sel_c, wb_sel_c, alu_a_sel_c;
    logic       alu_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            cls_q   <= C_OP;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        cnt_d      = cnt_q;
        ill_d      = ill_q;
        berr_d     = berr_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 2'd0;
        rf_we_c    = 1'b0;
        wb_sel_c   = 2'd0;
        retired_c  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_rvalid_i) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        state_d = S_TRAP;
                        berr_d  = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                unique case (opcode_i)
                    OPC_OP:     cls_d = C_OP;
                    OPC_OPIMM:  cls_d = C_OPIMM;
                    OPC_LOAD:   cls_d = C_LOAD;
                    OPC_STORE:  cls_d = C_STORE;
                    OPC_BRANCH: cls_d = C_BRANCH;
                    OPC_JAL:    cls_d = C_JAL;
                    OPC_JALR:   cls_d = C_JALR;
                    OPC_LUI:    cls_d = C_LUI;
                    OPC_AUIPC:  cls_d = C_AUIPC;
                    default: begin
                        state_d = S_TRAP;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if (cls_q == C_BRANCH) begin
                    pc_we_c   = 1'b1;
                    pc_sel_c  = branch_taken_i ? 2'd1 : 2'd0;
                    retired_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls_q == C_STORE);
                if (dmem_rvalid_i) begin
                    if (cls_q == C_STORE) begin
                        pc_we_c   = 1'b1;
                        retired_c = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        state_d = S_TRAP;
                        berr_d  = 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_we_c   = 1'b1;
                pc_we_c   = 1'b1;
                retired_c = 1'b1;
                state_d   = S_FETCH;
                unique case (1'b1)
                    (cls_q == C_LOAD): wb_sel_c = 2'd1;
                    (cls_q == C_JAL):  begin
                        wb_sel_c = 2'd2;
                        pc_sel_c = 2'd1;
                    end
                    (cls_q == C_JALR): begin
                        wb_sel_c = 2'd2;
                        pc_sel_c = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        // each wait state starts with a fresh timeout window
        if (state_d != state_q &&
            (state_d == S_FETCH || state_d == S_MEM))
            cnt_d = '0;
    end

    assign alu_valid = (state_q == S_EXEC) || (state_q == S_MEM) ||
                       (state_q == S_WB);

    always_comb begin
        alu_a_sel_c = 2'd0;
        alu_b_imm_c = 1'b0;
        if (alu_valid) begin
            unique case (1'b1)
                (cls_q == C_AUIPC): begin
                    alu_a_sel_c = 2'd1;
                    alu_b_imm_c = 1'b1;
                end
                (cls_q == C_JAL):  alu_a_sel_c = 2'd1;
                (cls_q == C_LUI): begin
                    alu_a_sel_c = 2'd2;
                    alu_b_imm_c = 1'b1;
                end
                (cls_q == C_OPIMM), (cls_q == C_LOAD),
                (cls_q == C_STORE), (cls_q == C_JALR):
                    alu_b_imm_c = 1'b1;
                default: ;
            endcase
        end
    end

    // strobes are masked by reset so requests drop without waiting for a clock
    assign imem_req_o      = imem_req_c & rst_ni;
    assign dmem_req_o      = dmem_req_c & rst_ni;
    assign dmem_we_o       = dmem_we_c & rst_ni;
    assign ir_we_o         = ir_we_c & rst_ni;
    assign pc_we_o         = pc_we_c & rst_ni;
    assign rf_we_o         = rf_we_c & rst_ni;
    assign instr_retired_o = retired_c & rst_ni;
    assign alu_b_imm_o     = alu_b_imm_c & rst_ni;
    assign pc_sel_o        = pc_sel_c & {2{rst_ni}};
    assign wb_sel_o        = wb_sel_c & {2{rst_ni}};
    assign alu_a_sel_o     = alu_a_sel_c & {2{rst_ni}};
    assign state_o         = state_q;
    assign illegal_o       = ill_q;
    assign bus_err_o       = berr_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
// Runs with TIMEOUT_CYCLES=4 so the fetch timeout is reachable quickly.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [6:0] opcode_i;
    logic       branch_taken_i;
    logic       imem_req_o;
    logic       imem_rvalid_i;
    logic       dmem_req_o;
    logic       dmem_we_o;
    logic       dmem_rvalid_i;
    logic       ir_we_o;
    logic       pc_we_o;
    logic [1:0] pc_sel_o;
    logic       rf_we_o;
    logic [1:0] wb_sel_o;
    logic [1:0] alu_a_sel_o;
    logic       alu_b_imm_o;
    logic       instr_retired_o;
    logic [2:0] state_o;
    logic       illegal_o;
    logic       bus_err_o;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i),
        .branch_taken_i(branch_taken_i), .imem_req_o(imem_req_o),
        .imem_rvalid_i(imem_rvalid_i), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_rvalid_i(dmem_rvalid_i),
        .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
        .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
        .alu_a_sel_o(alu_a_sel_o), .alu_b_imm_o(alu_b_imm_o),
        .instr_retired_o(instr_retired_o), .state_o(state_o),
        .illegal_o(illegal_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    // leaves the bench at a falling edge, first FETCH cycle pending
    task automatic do_reset();
        rst_ni = 1'b0;
        imem_rvalid_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        branch_taken_i = 1'b0;
        opcode_i = 7'd0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        imem_rvalid_i = 1'b1;
        dmem_rvalid_i = 1'b0;
        branch_taken_i = 1'b0;
        opcode_i = 7'd0;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL rst_state got %0d exp 0", state_o);
        end
        checks++;
        if ({imem_req_o, ir_we_o, dmem_req_o, pc_we_o, rf_we_o,
             instr_retired_o, illegal_o, bus_err_o} !== 8'd0) begin
            errors++;
            $display("FAIL rst_strobes got %b exp 0", {imem_req_o,
                ir_we_o, dmem_req_o, pc_we_o, rf_we_o, instr_retired_o,
                illegal_o, bus_err_o});
        end
        @(negedge clk_i);
        imem_rvalid_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        checks++;
        if (imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_req got %b exp 1", imem_req_o);
        end
    endtask

    task automatic test_addi();
        logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        do_reset();
        opcode_i = 7'b0010011;
        for (int i = 0; i < 5; i++) begin
            imem_rvalid_i = (i == 0);
            #1;
            checks++;
            if (state_o !== exp_st[i]) begin
                errors++;
                $display("FAIL addi_state[%0d] got %0d exp %0d",
                         i, state_o, exp_st[i]);
            end
            checks++;
            if (instr_retired_o !== (i == 3)) begin
                errors++;
                $display("FAIL addi_retire[%0d] got %b exp %b",
                         i, instr_retired_o, (i == 3));
            end
            if (i == 3) begin
                checks++;
                if ({rf_we_o, wb_sel_o, alu_b_imm_o, pc_sel_o, pc_we_o}
                    !== 7'b1_00_1_00_1) begin
                    errors++;
                    $display("FAIL addi_wb got %b exp 1001001", {rf_we_o,
                        wb_sel_o, alu_b_imm_o, pc_sel_o, pc_we_o});
                end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_load();
        int reqs = 0;
        int ret_at = -1;
        do_reset();
        opcode_i = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            imem_rvalid_i = (i == 0);
            dmem_rvalid_i = (i == 5);
            #1;
            if (dmem_req_o === 1'b1) begin
                reqs++;
                checks++;
                if (dmem_we_o !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_we[%0d] got %b exp 0", i, dmem_we_o);
                end
            end
            if (instr_retired_o === 1'b1) ret_at = i;
            if (i == 6) begin
                checks++;
                if ({state_o, wb_sel_o, rf_we_o} !== {3'd4, 2'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL lw_wb got st=%0d wb=%0d rf=%b exp 4 1 1",
                             state_o, wb_sel_o, rf_we_o);
                end
            end
            @(negedge clk_i);
        end
        dmem_rvalid_i = 1'b0;
        checks++;
        if (reqs != 3) begin
            errors++;
            $display("FAIL lw_req_cycles got %0d exp 3", reqs);
        end
        checks++;
        if (ret_at != 6) begin
            errors++;
            $display("FAIL lw_retire_cycle got %0d exp 6", ret_at);
        end
    endtask

    task automatic test_branch();
        do_reset();
        opcode_i = 7'b1100011;
        for (int t = 1; t >= 0; t--) begin
            imem_rvalid_i = 1'b1;
            @(negedge clk_i);
            imem_rvalid_i = 1'b0;
            @(negedge clk_i);
            branch_taken_i = t[0];
            #1;
            checks++;
            if ({state_o, pc_we_o, pc_sel_o, rf_we_o, instr_retired_o}
                !== {3'd2, 1'b1, 2'(t), 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL beq_exec taken=%0d got st=%0d pcwe=%b sel=%0d rf=%b ret=%b",
                         t, state_o, pc_we_o, pc_sel_o, rf_we_o,
                         instr_retired_o);
            end
            @(negedge clk_i);
            branch_taken_i = 1'b0;
            #1;
            checks++;
            if (state_o !== 3'd0) begin
                errors++;
                $display("FAIL beq_next taken=%0d got %0d exp 0", t, state_o);
            end
        end
    endtask

    task automatic test_jumps();
        logic [6:0] opc [4] = '{7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111};
        logic [1:0] e_wb [4] = '{2'd2, 2'd2, 2'd0, 2'd0};
        logic [1:0] e_pc [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
        logic [1:0] e_a  [4] = '{2'd1, 2'd0, 2'd2, 2'd1};
        logic       e_b  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            opcode_i = opc[k];
            imem_rvalid_i = 1'b1;
            @(negedge clk_i);
            imem_rvalid_i = 1'b0;
            repeat (2) @(negedge clk_i);
            #1;
            checks++;
            if ({state_o, wb_sel_o, pc_sel_o, alu_a_sel_o, alu_b_imm_o}
                !== {3'd4, e_wb[k], e_pc[k], e_a[k], e_b[k]}) begin
                errors++;
                $display("FAIL jump_wb[%0d] got st=%0d wb=%0d pc=%0d a=%0d b=%b",
                         k, state_o, wb_sel_o, pc_sel_o, alu_a_sel_o,
                         alu_b_imm_o);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_illegal();
        int reqs = 0;
        do_reset();
        opcode_i = 7'b0000000;
        imem_rvalid_i = 1'b1;
        @(negedge clk_i);
        imem_rvalid_i = 1'b0;
        @(negedge clk_i);
        #1;
        checks++;
        if ({state_o, illegal_o} !== {3'd7, 1'b1}) begin
            errors++;
            $display("FAIL ill_trap got st=%0d ill=%b exp 7 1",
                     state_o, illegal_o);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            imem_rvalid_i = i[0];
            dmem_rvalid_i = i[1];
            #1;
            if (imem_req_o || ir_we_o || instr_retired_o || state_o != 3'd7)
                reqs++;
        end
        imem_rvalid_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL ill_quiet got %0d active cycles exp 0", reqs);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({illegal_o, state_o, imem_req_o} !== {1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL ill_clear got ill=%b st=%0d req=%b exp 0 0 0",
                     illegal_o, state_o, imem_req_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (4) @(negedge clk_i);
        #1;
        checks++;
        if ({state_o, bus_err_o, imem_req_o} !== {3'd7, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL tmo_trap got st=%0d err=%b req=%b exp 7 1 0",
                     state_o, bus_err_o, imem_req_o);
        end
        do_reset();
        #1;
        checks++;
        if (bus_err_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear got %b exp 0", bus_err_o);
        end
        opcode_i = 7'b0110011;
        repeat (3) @(negedge clk_i);
        imem_rvalid_i = 1'b1;
        #1;
        checks++;
        if ({state_o, ir_we_o} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL tmo_late_accept got st=%0d irwe=%b exp 0 1",
                     state_o, ir_we_o);
        end
        @(negedge clk_i);
        imem_rvalid_i = 1'b0;
        #1;
        checks++;
        if ({state_o, bus_err_o} !== {3'd1, 1'b0}) begin
            errors++;
            $display("FAIL tmo_decode got st=%0d err=%b exp 1 0",
                     state_o, bus_err_o);
        end
    endtask

    task automatic test_store_reset();
        do_reset();
        opcode_i = 7'b0100011;
        imem_rvalid_i = 1'b1;
        @(negedge clk_i);
        imem_rvalid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if ({state_o, dmem_req_o, dmem_we_o} !== {3'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sw_mem got st=%0d req=%b we=%b exp 3 1 1",
                     state_o, dmem_req_o, dmem_we_o);
        end
        #2;
        rst_ni = 1'b0;
        dmem_rvalid_i = 1'b1;
        #1;
        checks++;
        if ({dmem_req_o, state_o, instr_retired_o, pc_we_o}
            !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sw_async_rst got req=%b st=%0d ret=%b pcwe=%b",
                     dmem_req_o, state_o, instr_retired_o, pc_we_o);
        end
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        rst_ni = 1'b1;
        imem_rvalid_i = 1'b1;
        #1;
        checks++;
        if ({imem_req_o, ir_we_o} !== 2'b11) begin
            errors++;
            $display("FAIL sw_resume got req=%b irwe=%b exp 1 1",
                     imem_req_o, ir_we_o);
        end
        @(negedge clk_i);
        imem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL sw_resume_decode got %0d exp 1", state_o);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_branch();
        test_jumps();
        test_illegal();
        test_timeout();
        test_store_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
